// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage:
// operation codes and mul/div FSM encoding.
package exe_stage_pkg;

  localparam logic [3:0] EXE_CMD_ADD  = 4'd0;
  localparam logic [3:0] EXE_CMD_SUB  = 4'd1;
  localparam logic [3:0] EXE_CMD_AND  = 4'd2;
  localparam logic [3:0] EXE_CMD_OR   = 4'd3;
  localparam logic [3:0] EXE_CMD_NOR  = 4'd4;
  localparam logic [3:0] EXE_CMD_XOR  = 4'd5;
  localparam logic [3:0] EXE_CMD_SLL  = 4'd6;
  localparam logic [3:0] EXE_CMD_SRL  = 4'd7;
  localparam logic [3:0] EXE_CMD_SRA  = 4'd8;
  localparam logic [3:0] EXE_CMD_MUL  = 4'd9;
  localparam logic [3:0] EXE_CMD_DIVU = 4'd10;
  localparam logic [3:0] EXE_CMD_REMU = 4'd11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic        wb_en;
    logic [1:0]  mem_sig;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] reg2;
  } exe_mem_t;

  function automatic logic is_md_cmd(
    input logic [3:0] cmd
  );
    return (cmd == EXE_CMD_MUL) ||
           (cmd == EXE_CMD_DIVU) ||
           (cmd == EXE_CMD_REMU);
  endfunction

endpackage

// File: rtl/exe_stage_iter_muldiv.sv
// Iterative unsigned multiply / divide unit.
// One shift-add or restoring step per cycle.
module iter_muldiv
  import exe_stage_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int CW = $clog2(MD_CYCLES);

  md_state_e   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]  op;
  logic [31:0] acc, opa, opb;
  logic [31:0] acc_nxt, opa_nxt, opb_nxt;
  logic [32:0] rsh, diff;
  logic        start;

  assign start = req && (state == MD_IDLE);
  assign busy  = start || (state == MD_BUSY);
  assign done  = (state == MD_DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; DONE never re-arms on the held op
  always_comb begin
    state_nxt = state;
    unique case (state)
      MD_IDLE: if (start) state_nxt = MD_BUSY;
      MD_BUSY: if (cnt == '0) state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring for DIVU/REMU
  always_comb begin
    rsh     = {acc, opa[31]};
    diff    = rsh - {1'b0, opb};
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (op == EXE_CMD_MUL) begin
      acc_nxt = opb[0] ? acc + opa : acc;
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end else if (!diff[32]) begin
      acc_nxt = diff[31:0];
      opa_nxt = {opa[30:0], 1'b1};
    end else begin
      acc_nxt = rsh[31:0];
      opa_nxt = {opa[30:0], 1'b0};
    end
  end

  // Operand, accumulator and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      opa <= '0;
      opb <= '0;
      cnt <= '0;
      op  <= '0;
    end else if (start) begin
      acc <= '0;
      opa <= a;
      opb <= b;
      cnt <= CW'(MD_CYCLES - 1);
      op  <= cmd;
    end else if (state == MD_BUSY) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Quotient lives in opa; product and remainder in acc
  always_comb begin
    result = acc;
    if (op == EXE_CMD_DIVU) result = opa;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, iterative
// mul/div with upstream stall, EXE/MEM register.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_En_ID,
  input  logic [1:0]  MEM_Signal_ID,
  input  logic [4:0]  dest_ID,
  input  logic [3:0]  EXE_CMD_ID,
  input  logic [31:0] val1_ID,
  input  logic [31:0] val2_ID,
  input  logic [31:0] reg2_ID,
  output logic        stall_EXE,
  output logic        WB_En_EXE,
  output logic [1:0]  MEM_Signal_EXE,
  output logic [4:0]  dest_EXE,
  output logic [31:0] ALU_result_EXE,
  output logic [31:0] reg2_EXE
);

  logic [31:0] alu_res, md_res, res;
  logic [4:0]  shamt;
  logic        md_busy, md_done;
  exe_mem_t    d, q;

  assign shamt = val2_ID[4:0];

  iter_muldiv #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md (
    .clk    (clk),
    .rst    (rst),
    .req    (is_md_cmd(EXE_CMD_ID)),
    .cmd    (EXE_CMD_ID),
    .a      (val1_ID),
    .b      (val2_ID),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  // No stall can be raised while reset is held
  assign stall_EXE = rst & md_busy;

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    unique case (EXE_CMD_ID)
      EXE_CMD_ADD: alu_res = val1_ID + val2_ID;
      EXE_CMD_SUB: alu_res = val1_ID - val2_ID;
      EXE_CMD_AND: alu_res = val1_ID & val2_ID;
      EXE_CMD_OR:  alu_res = val1_ID | val2_ID;
      EXE_CMD_NOR: alu_res = ~(val1_ID | val2_ID);
      EXE_CMD_XOR: alu_res = val1_ID ^ val2_ID;
      EXE_CMD_SLL: alu_res = val1_ID << shamt;
      EXE_CMD_SRL: alu_res = val1_ID >> shamt;
      EXE_CMD_SRA: alu_res = $signed(val1_ID) >>> shamt;
      default:     alu_res = '0;
    endcase
  end

  assign res = md_done ? md_res : alu_res;

  assign d = '{
    wb_en:   WB_En_ID,
    mem_sig: MEM_Signal_ID,
    dest:    dest_ID,
    alu_res: res,
    reg2:    reg2_ID
  };

  // EXE/MEM register; a stall loads an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           q <= '0;
    else if (stall_EXE) q <= '0;
    else                q <= d;
  end

  assign WB_En_EXE      = q.wb_en;
  assign MEM_Signal_EXE = q.mem_sig;
  assign dest_EXE       = q.dest;
  assign ALU_result_EXE = q.alu_res;
  assign reg2_EXE       = q.reg2;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage with a
// scoreboard queue of expected EXE/MEM contents.
module tb_exe_stage;
  import exe_stage_pkg::*;

  typedef struct packed {
    logic        wb;
    logic [1:0]  ms;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] reg2;
  } out_t;

  logic        clk;
  logic        rst;
  logic        WB_En_ID;
  logic [1:0]  MEM_Signal_ID;
  logic [4:0]  dest_ID;
  logic [3:0]  EXE_CMD_ID;
  logic [31:0] val1_ID, val2_ID, reg2_ID;
  logic        stall_EXE;
  logic        WB_En_EXE;
  logic [1:0]  MEM_Signal_EXE;
  logic [4:0]  dest_EXE;
  logic [31:0] ALU_result_EXE, reg2_EXE;

  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  exe_stage #(.MD_CYCLES(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .WB_En_ID       (WB_En_ID),
    .MEM_Signal_ID  (MEM_Signal_ID),
    .dest_ID        (dest_ID),
    .EXE_CMD_ID     (EXE_CMD_ID),
    .val1_ID        (val1_ID),
    .val2_ID        (val2_ID),
    .reg2_ID        (reg2_ID),
    .stall_EXE      (stall_EXE),
    .WB_En_EXE      (WB_En_EXE),
    .MEM_Signal_EXE (MEM_Signal_EXE),
    .dest_EXE       (dest_EXE),
    .ALU_result_EXE (ALU_result_EXE),
    .reg2_EXE       (reg2_EXE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t outs();
    return {WB_En_EXE, MEM_Signal_EXE, dest_EXE,
            ALU_result_EXE, reg2_EXE};
  endfunction

  function automatic logic [31:0] model(
    input logic [3:0] c, input logic [31:0] a, b);
    logic [31:0] r;
    r = 32'd0;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = ~(a | b);
      4'd5:  r = a ^ b;
      4'd6:  r = a << b[4:0];
      4'd7:  r = a >> b[4:0];
      4'd8:  r = $signed(a) >>> b[4:0];
      4'd9:  r = a * b;
      4'd10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic drive_nop();
    WB_En_ID = 1'b0; MEM_Signal_ID = 2'b00;
    dest_ID = 5'd0; EXE_CMD_ID = 4'd12;
    val1_ID = 32'd0; val2_ID = 32'd0;
    reg2_ID = 32'd0;
  endtask

  // Issue one op, push its expectation, wait until captured
  task automatic run_op(
    input logic [3:0] c, input logic [31:0] a, b, r2,
    input logic wb, input logic [1:0] ms,
    input logic [4:0] dst,
    output int stalls, output int bad, output out_t got);
    bit fin;
    int n;
    sb.push_back({wb, ms, dst, model(c, a, b), r2});
    WB_En_ID = wb; MEM_Signal_ID = ms; dest_ID = dst;
    EXE_CMD_ID = c; val1_ID = a; val2_ID = b;
    reg2_ID = r2;
    stalls = 0; bad = 0; fin = 0; n = 0;
    while (!fin && n < 100) begin
      #1;
      if (stall_EXE) begin
        stalls++;
        @(posedge clk); #1;
        if (outs() !== '0) bad++;
      end else begin
        @(posedge clk); #1;
        fin = 1;
      end
      n++;
    end
    if (!fin) stalls = -1;
    got = outs();
    drive_nop();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    WB_En_ID = 1'b1; MEM_Signal_ID = 2'($urandom);
    dest_ID = 5'($urandom); EXE_CMD_ID = 4'd9;
    val1_ID = $urandom; val2_ID = $urandom;
    reg2_ID = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      EXE_CMD_ID = 4'($urandom);
      #1;
      checks++;
      if (stall_EXE !== 1'b0 || outs() !== '0) begin
        errors++;
        $display("FAIL reset_hold: stall=%b out=%h want 0",
                 stall_EXE, outs());
      end
    end
    WB_En_ID = 1'b0; MEM_Signal_ID = 2'b00;
    dest_ID = 5'd0; EXE_CMD_ID = 4'd0;
    val1_ID = 32'd0; val2_ID = 32'd0; reg2_ID = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stall_EXE !== 1'b0 || outs() !== '0) begin
      errors++;
      $display("FAIL reset_release: stall=%b out=%h want 0",
               stall_EXE, outs());
    end
    @(posedge clk); #1;
    checks++;
    if (stall_EXE !== 1'b0 || outs() !== '0) begin
      errors++;
      $display("FAIL reset_after: stall=%b out=%h want 0",
               stall_EXE, outs());
    end
  endtask

  task automatic test_alu();
    logic [3:0]  c[10];
    logic [31:0] a[10], b[10];
    int   st, bad;
    out_t got, exp;
    c = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
          4'd5, 4'd6, 4'd7, 4'd8, 4'd14};
    a = '{32'd7, 32'd0, 32'hF0F0_1234, 32'hF000_0001,
          32'h0F0F_0000, 32'hAAAA_5555, 32'd1,
          32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    b = '{32'd5, 32'd1, 32'h0FF0_FF00, 32'h0000_1110,
          32'h0000_F00F, 32'hFFFF_0000, 32'h0000_003F,
          32'd4, 32'd4, 32'h9};
    for (int i = 0; i < 10; i++) begin
      run_op(c[i], a[i], b[i], 32'h100 + i, 1'b1,
             2'b00, 5'd3, st, bad, got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp || st !== 0) begin
        errors++;
        $display("FAIL alu_cmd%0d: got %h stall %0d want %h stall 0",
                 c[i], got, st, exp);
      end
      if (i == 0) begin
        checks++;
        if (got.res !== 32'd12 || got.dest !== 5'd3 ||
            got.wb !== 1'b1) begin
          errors++;
          $display("FAIL add_7_5: got %h want res 12 dest 3 wb 1",
                   got);
        end
      end
      if (i == 1) begin
        checks++;
        if (got.res !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL sub_0_1: got %h want ffffffff",
                   got.res);
        end
      end
    end
  endtask

  task automatic test_mul();
    int   st, bad;
    out_t got, exp;
    run_op(4'd9, 32'h0001_0003, 32'h0000_0005, 32'd0,
           1'b1, 2'b00, 5'd8, st, bad, got);
    exp = sb.pop_front();
    checks++;
    if (st !== 33 || bad !== 0) begin
      errors++;
      $display("FAIL mul_stall: stall %0d bad %0d want 33 0",
               st, bad);
    end
    checks++;
    if (got !== exp || got.res !== 32'h0005_000F ||
        got.wb !== 1'b1) begin
      errors++;
      $display("FAIL mul_result: got %h want res 0005000f",
               got);
    end
    run_op(4'd0, 32'd40, 32'd2, 32'd0, 1'b1, 2'b00,
           5'd4, st, bad, got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp || st !== 0) begin
      errors++;
      $display("FAIL mul_next_add: got %h stall %0d want %h 0",
               got, st, exp);
    end
  endtask

  task automatic test_div();
    logic [3:0]  c[4];
    logic [31:0] a[4], b[4], k[4];
    int   st, bad;
    out_t got, exp;
    c = '{4'd10, 4'd11, 4'd10, 4'd11};
    a = '{32'd100, 32'd100, 32'd9, 32'd9};
    b = '{32'd7, 32'd7, 32'd0, 32'd0};
    k = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    for (int i = 0; i < 4; i++) begin
      run_op(c[i], a[i], b[i], 32'd0, 1'b1, 2'b00,
             5'd5, st, bad, got);
      exp = sb.pop_front();
      checks++;
      if (st !== 33 || bad !== 0) begin
        errors++;
        $display("FAIL div%0d_stall: stall %0d bad %0d want 33 0",
                 i, st, bad);
      end
      checks++;
      if (got !== exp || got.res !== k[i]) begin
        errors++;
        $display("FAIL div%0d_result: got %h want res %h",
                 i, got.res, k[i]);
      end
    end
  endtask

  task automatic test_passthrough();
    int   st, bad;
    out_t got, exp;
    run_op(4'd0, 32'd1024, 32'd8, 32'hDEAD_BEEF, 1'b0,
           2'b01, 5'd0, st, bad, got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp || got.res !== 32'd1032 ||
        got.ms !== 2'b01 || got.reg2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_pass: got %h want %h", got, exp);
    end
  endtask

  task automatic test_mid_reset();
    int   st, bad;
    out_t got, exp;
    @(posedge clk); #1;
    WB_En_ID = 1'b1; MEM_Signal_ID = 2'b00; dest_ID = 5'd6;
    EXE_CMD_ID = 4'd10; val1_ID = 32'd1000;
    val2_ID = 32'd3; reg2_ID = 32'd0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (stall_EXE !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: stall=%b want 1", stall_EXE);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (stall_EXE !== 1'b0 || outs() !== '0) begin
      errors++;
      $display("FAIL midrst_clear: stall=%b out=%h want 0",
               stall_EXE, outs());
    end
    drive_nop();
    @(negedge clk);
    rst = 1'b1;
    run_op(4'd0, 32'd20, 32'd22, 32'd0, 1'b1, 2'b00,
           5'd9, st, bad, got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp || st !== 0 || got.res !== 32'd42) begin
      errors++;
      $display("FAIL midrst_add: got %h stall %0d want %h 0",
               got, st, exp);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (stall_EXE !== 1'b0 || outs() !== '0) begin
      errors++;
      $display("FAIL midrst_stale: stall=%b out=%h want 0",
               stall_EXE, outs());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c;
    logic [31:0] a, b;
    int   st, bad, want;
    out_t got, exp;
    for (int i = 0; i < 14; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      want = is_md_cmd(c) ? 33 : 0;
      run_op(c, a, b, $urandom, 1'($urandom),
             2'($urandom), 5'($urandom), st, bad, got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp || st !== want || bad !== 0) begin
        errors++;
        $display("FAIL b2b%0d_cmd%0d: got %h st %0d want %h st %0d",
                 i, c, got, st, exp, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_passthrough();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
